// File: rtl/pre_hash_pe_dispatcher.sv
// Pre-hash PE dispatcher: splits one window of hashed positions into
// conflict-free rounds, one position per hash PE bank per round.
// Optional feature macro: PRE_HASH_DISPATCH_PERF_EN adds perf counter ports.
// Ports: clk, rst_n (sync, active-low); input_* window handshake
//   (valid/ready, head_addr, mask, hash_vec, data, delim);
//   output_* round handshake (valid/ready, mask, addr_vec, hash_vec,
//   data, head_addr, delim, last); perf_*_cnt when the macro is defined.

`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 4
`endif
`ifndef NUM_HASH_PE
`define NUM_HASH_PE 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef HASH_BITS
`define HASH_BITS 12
`endif

module pre_hash_pe_dispatcher #(
  parameter int ISSUE_W = `HASH_ISSUE_WIDTH,
  parameter int NUM_PE  = `NUM_HASH_PE,
  parameter int AW      = `ADDR_WIDTH,
  parameter int HW      = `HASH_BITS,
  localparam int PE_LOG2 = $clog2(NUM_PE),
  localparam int LW      = HW - PE_LOG2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [AW-1:0]          input_head_addr,
  input  logic [ISSUE_W-1:0]     input_mask,
  input  logic [ISSUE_W*HW-1:0]  input_hash_vec,
  input  logic [ISSUE_W*8-1:0]   input_data,
  input  logic                   input_delim,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [NUM_PE-1:0]      output_mask,
  output logic [NUM_PE*AW-1:0]   output_addr_vec,
  output logic [NUM_PE*LW-1:0]   output_hash_vec,
  output logic [ISSUE_W*8-1:0]   output_data,
  output logic [AW-1:0]          output_head_addr,
  output logic                   output_delim,
`ifdef PRE_HASH_DISPATCH_PERF_EN
  output logic [31:0]            perf_window_cnt,
  output logic [31:0]            perf_round_cnt,
  output logic [31:0]            perf_conflict_cnt,
`endif
  output logic                   output_last
);

  typedef enum logic {
    IDLE,
    DISPATCH
  } state_t;

  state_t state, state_nx;

  logic [ISSUE_W-1:0]    pend, pend_nx, clr;
  logic [AW-1:0]         head_r;
  logic [ISSUE_W*HW-1:0] hash_r;
  logic [ISSUE_W*8-1:0]  data_r;
  logic                  delim_r;

  logic              busy, last, hs_in, hs_out;
  logic [NUM_PE-1:0] sel;
  int                sel_idx [NUM_PE];

  // Lowest pending position per bank wins; its bit is cleared on handshake.
  always_comb begin : pick
    sel = '0;
    clr = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      sel_idx[p] = 0;
      for (int i = 0; i < ISSUE_W; i++) begin
        if (!sel[p] && pend[i] &&
            hash_r[i*HW +: PE_LOG2] == PE_LOG2'(p)) begin
          sel[p]     = 1'b1;
          sel_idx[p] = i;
          clr[i]     = 1'b1;
        end
      end
    end
  end

  always_comb begin : lanes
    output_addr_vec = '0;
    output_hash_vec = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      if (sel[p]) begin
        output_addr_vec[p*AW +: AW] =
          head_r + AW'(sel_idx[p]);
        output_hash_vec[p*LW +: LW] =
          hash_r[sel_idx[p]*HW + PE_LOG2 +: LW];
      end
    end
  end

  assign busy   = (state == DISPATCH);
  assign last   = ~|(pend & ~clr);
  assign hs_out = busy & output_ready;
  assign hs_in  = input_valid & input_ready;

  // Accepting on the last round's handshake keeps windows bubble-free.
  assign input_ready = ~busy | (hs_out & last);

  assign output_valid     = busy;
  assign output_mask      = sel;
  assign output_last      = last;
  assign output_delim     = delim_r & last;
  assign output_data      = data_r;
  assign output_head_addr = head_r;

  always_comb begin : fsm_nx
    state_nx = state;
    pend_nx  = pend;
    if (hs_out) begin
      pend_nx = pend & ~clr;
      if (last) state_nx = IDLE;
    end
    if (hs_in) begin
      state_nx = DISPATCH;
      pend_nx  = input_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      head_r  <= '0;
      hash_r  <= '0;
      data_r  <= '0;
      delim_r <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      if (hs_in) begin
        head_r  <= input_head_addr;
        hash_r  <= input_hash_vec;
        data_r  <= input_data;
        delim_r <= input_delim;
      end
    end
  end

`ifdef PRE_HASH_DISPATCH_PERF_EN
  logic        first_r;
  logic [31:0] win_c, rnd_c, cfl_c;

  // first_r marks that the upcoming round is the window's first one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_r <= 1'b0;
      win_c   <= '0;
      rnd_c   <= '0;
      cfl_c   <= '0;
    end else begin
      if (hs_in)       first_r <= 1'b1;
      else if (hs_out) first_r <= 1'b0;
      if (hs_in && win_c != '1)  win_c <= win_c + 32'd1;
      if (hs_out && rnd_c != '1) rnd_c <= rnd_c + 32'd1;
      if (hs_out && !first_r && cfl_c != '1)
        cfl_c <= cfl_c + 32'd1;
    end
  end

  assign perf_window_cnt   = win_c;
  assign perf_round_cnt    = rnd_c;
  assign perf_conflict_cnt = cfl_c;
`endif

endmodule

// File: tb/tb_pre_hash_pe_dispatcher.sv
// Scoreboard bench for pre_hash_pe_dispatcher (ISSUE_W=4, NUM_PE=4,
// AW=32, HW=12); directed windows push expected rounds, a monitor checks.

module tb_pre_hash_pe_dispatcher;

  localparam int IW = 4;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int HW = 12;
  localparam int LW = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [AW-1:0]    input_head_addr = '0;
  logic [IW-1:0]    input_mask = '0;
  logic [IW*HW-1:0] input_hash_vec = '0;
  logic [IW*8-1:0]  input_data = '0;
  logic             input_delim = 1'b0;
  logic             output_valid;
  logic             output_ready = 1'b1;
  logic [NP-1:0]    output_mask;
  logic [NP*AW-1:0] output_addr_vec;
  logic [NP*LW-1:0] output_hash_vec;
  logic [IW*8-1:0]  output_data;
  logic [AW-1:0]    output_head_addr;
  logic             output_delim;
  logic             output_last;
`ifdef PRE_HASH_DISPATCH_PERF_EN
  logic [31:0]      perf_window_cnt;
  logic [31:0]      perf_round_cnt;
  logic [31:0]      perf_conflict_cnt;
`endif

  always #5 clk = ~clk;

  pre_hash_pe_dispatcher #(
    .ISSUE_W(IW), .NUM_PE(NP), .AW(AW), .HW(HW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .input_head_addr(input_head_addr),
    .input_mask(input_mask),
    .input_hash_vec(input_hash_vec),
    .input_data(input_data),
    .input_delim(input_delim),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_mask(output_mask),
    .output_addr_vec(output_addr_vec),
    .output_hash_vec(output_hash_vec),
    .output_data(output_data),
    .output_head_addr(output_head_addr),
    .output_delim(output_delim),
`ifdef PRE_HASH_DISPATCH_PERF_EN
    .perf_window_cnt(perf_window_cnt),
    .perf_round_cnt(perf_round_cnt),
    .perf_conflict_cnt(perf_conflict_cnt),
`endif
    .output_last(output_last)
  );

  typedef struct packed {
    logic [3:0]   mask;
    logic [127:0] addr;
    logic [39:0]  hash;
    logic [31:0]  head;
    logic [31:0]  data;
    logic         delim;
    logic         last;
  } rnd_t;

  rnd_t q[$];
  rnd_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   waited;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_rnd(input logic [3:0] m,
                         input logic [127:0] a,
                         input logic [39:0] h,
                         input logic [31:0] hd,
                         input logic [31:0] d,
                         input logic dl,
                         input logic ls);
    rnd_t r;
    r.mask  = m;
    r.addr  = a;
    r.hash  = h;
    r.head  = hd;
    r.data  = d;
    r.delim = dl;
    r.last  = ls;
    q.push_back(r);
  endtask

  // Packs {local, bank} per position; args are packed pos3..pos0.
  function automatic logic [47:0] mkh(input logic [39:0] locs,
                                      input logic [7:0] banks);
    logic [47:0] r;
    for (int i = 0; i < 4; i++)
      r[i*12 +: 12] = {locs[i*10 +: 10], banks[i*2 +: 2]};
    return r;
  endfunction

  // Returns one phase after the accepting edge with input_valid still high.
  task automatic send(input logic [31:0] hd,
                      input logic [3:0] m,
                      input logic [47:0] hv,
                      input logic [31:0] d,
                      input logic dl,
                      output int cyc);
    bit ok;
    input_valid     = 1'b1;
    input_head_addr = hd;
    input_mask      = m;
    input_hash_vec  = hv;
    input_data      = d;
    input_delim     = dl;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      ok = input_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q.size() != 0 || output_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_drain"}, 128'(n < 100), 128'(1));
  endtask

  // Monitor: every valid cycle is checked against the queue head, so a
  // stalled round must hold its values; the head pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && output_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_round: got mask %b expected none",
                   output_mask);
        end else begin
          e = q[0];
          chk("out_mask", 128'(output_mask), 128'(e.mask));
          chk("out_addr", 128'(output_addr_vec), e.addr);
          chk("out_hash", 128'(output_hash_vec), 128'(e.hash));
          chk("out_head", 128'(output_head_addr), 128'(e.head));
          chk("out_data", 128'(output_data), 128'(e.data));
          chk("out_delim", 128'(output_delim), 128'(e.delim));
          chk("out_last", 128'(output_last), 128'(e.last));
          if (output_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(output_valid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(input_ready), 128'(1));
    chk("rst_data", 128'(output_data), 128'(0));
    chk("rst_head", 128'(output_head_addr), 128'(0));
    chk("rst_mask", 128'(output_mask), 128'(0));
`ifdef PRE_HASH_DISPATCH_PERF_EN
    chk("rst_perf_win", 128'(perf_window_cnt), 128'(0));
`endif

    // Conflict-free window.
    exp_rnd(4'b1111, {32'd103, 32'd102, 32'd101, 32'd100},
            {10'd44, 10'd33, 10'd22, 10'd11},
            32'd100, 32'hA1B2C3D4, 1'b0, 1'b1);
    send(32'd100, 4'b1111,
         mkh({10'd44, 10'd33, 10'd22, 10'd11}, {2'd3, 2'd2, 2'd1, 2'd0}),
         32'hA1B2C3D4, 1'b0, waited);
    input_valid = 1'b0;
    chk("t1_valid_next", 128'(output_valid), 128'(1));
    drain("t1");

    // Full conflict on bank 2; delim only on the final round.
    for (int k = 0; k < 4; k++)
      exp_rnd(4'b0100, 128'(100 + k) << 64, 40'(5 + k) << 20,
              32'd100, 32'h11223344, k == 3, k == 3);
    send(32'd100, 4'b1111,
         mkh({10'd8, 10'd7, 10'd6, 10'd5}, {2'd2, 2'd2, 2'd2, 2'd2}),
         32'h11223344, 1'b1, waited);
    input_valid = 1'b0;
    drain("t2");

    // Backpressure on round 1.
    output_ready = 1'b0;
    exp_rnd(4'b0011, {32'd0, 32'd0, 32'd102, 32'd100},
            {10'd0, 10'd0, 10'd3, 10'd1},
            32'd100, 32'h55667788, 1'b0, 1'b0);
    exp_rnd(4'b0011, {32'd0, 32'd0, 32'd103, 32'd101},
            {10'd0, 10'd0, 10'd4, 10'd2},
            32'd100, 32'h55667788, 1'b0, 1'b1);
    send(32'd100, 4'b1111,
         mkh({10'd4, 10'd3, 10'd2, 10'd1}, {2'd1, 2'd1, 2'd0, 2'd0}),
         32'h55667788, 1'b0, waited);
    input_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t3_in_ready_stall", 128'(input_ready), 128'(0));
      chk("t3_valid_stall", 128'(output_valid), 128'(1));
      @(posedge clk);
      #1;
    end
    output_ready = 1'b1;
    drain("t3");

    // Empty window carrying a delimiter.
    exp_rnd(4'b0000, 128'd0, 40'd0, 32'd200, 32'hCAFEF00D, 1'b1, 1'b1);
    send(32'd200, 4'b0000, 48'hABC_DEF_123_456,
         32'hCAFEF00D, 1'b1, waited);
    input_valid = 1'b0;
    drain("t4");

    // Sparse mask with address wrap: positions 0 and 2 both on bank 1.
    exp_rnd(4'b0010, {32'd0, 32'd0, 32'hFFFFFFFF, 32'd0},
            {10'd0, 10'd0, 10'd3, 10'd0},
            32'hFFFFFFFF, 32'h0BADBEEF, 1'b0, 1'b0);
    exp_rnd(4'b0010, {32'd0, 32'd0, 32'd1, 32'd0},
            {10'd0, 10'd0, 10'd5, 10'd0},
            32'hFFFFFFFF, 32'h0BADBEEF, 1'b0, 1'b1);
    send(32'hFFFFFFFF, 4'b0101,
         mkh({10'd7, 10'd5, 10'd9, 10'd3}, {2'd0, 2'd1, 2'd1, 2'd1}),
         32'h0BADBEEF, 1'b0, waited);
    input_valid = 1'b0;
    drain("t5");

    // Back-to-back windows with input_valid held.
    exp_rnd(4'b1111, {32'd3, 32'd2, 32'd1, 32'd0},
            {10'd4, 10'd3, 10'd2, 10'd1},
            32'd0, 32'h01020304, 1'b0, 1'b1);
    exp_rnd(4'b1111, {32'd4, 32'd5, 32'd6, 32'd7},
            {10'd9, 10'd8, 10'd7, 10'd6},
            32'd4, 32'h05060708, 1'b1, 1'b1);
    send(32'd0, 4'b1111,
         mkh({10'd4, 10'd3, 10'd2, 10'd1}, {2'd3, 2'd2, 2'd1, 2'd0}),
         32'h01020304, 1'b0, waited);
    chk("t6_a_valid", 128'(output_valid), 128'(1));
    send(32'd4, 4'b1111,
         mkh({10'd6, 10'd7, 10'd8, 10'd9}, {2'd0, 2'd1, 2'd2, 2'd3}),
         32'h05060708, 1'b1, waited);
    input_valid = 1'b0;
    chk("t6_b_wait", 128'(waited), 128'(1));
    chk("t6_b_valid", 128'(output_valid), 128'(1));
    chk("t6_b_head", 128'(output_head_addr), 128'(4));
    drain("t6");

`ifdef PRE_HASH_DISPATCH_PERF_EN
    chk("perf_win", 128'(perf_window_cnt), 128'(7));
    chk("perf_rnd", 128'(perf_round_cnt), 128'(12));
    chk("perf_cfl", 128'(perf_conflict_cnt), 128'(5));
`endif

    // Reset during round 2 of a full-conflict window.
    for (int k = 0; k < 4; k++)
      exp_rnd(4'b0100, 128'(100 + k) << 64, 40'(5 + k) << 20,
              32'd100, 32'h99887766, 1'b0, k == 3);
    send(32'd100, 4'b1111,
         mkh({10'd8, 10'd7, 10'd6, 10'd5}, {2'd2, 2'd2, 2'd2, 2'd2}),
         32'h99887766, 1'b0, waited);
    input_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_round2_addr", 128'(output_addr_vec[95:64]), 128'(101));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk("t7_valid_rst", 128'(output_valid), 128'(0));
    chk("t7_data_rst", 128'(output_data), 128'(0));
`ifdef PRE_HASH_DISPATCH_PERF_EN
    chk("t7_perf_win", 128'(perf_window_cnt), 128'(0));
    chk("t7_perf_rnd", 128'(perf_round_cnt), 128'(0));
    chk("t7_perf_cfl", 128'(perf_conflict_cnt), 128'(0));
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t7_valid_idle", 128'(output_valid), 128'(0));
    chk("t7_in_ready", 128'(input_ready), 128'(1));

    exp_rnd(4'b1111, {32'd103, 32'd102, 32'd101, 32'd100},
            {10'd44, 10'd33, 10'd22, 10'd11},
            32'd100, 32'hA1B2C3D4, 1'b0, 1'b1);
    send(32'd100, 4'b1111,
         mkh({10'd44, 10'd33, 10'd22, 10'd11}, {2'd3, 2'd2, 2'd1, 2'd0}),
         32'hA1B2C3D4, 1'b0, waited);
    input_valid = 1'b0;
    drain("t7_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pre_hash_pe_dispatcher.md
PRE_HASH_PE_DISPATCHER -- requirements
Module: pre_hash_pe_dispatcher

Interface
REQ-001 The block SHALL have parameter ISSUE_W, default `HASH_ISSUE_WIDTH, meaning positions per input window.
REQ-002 The block SHALL have parameter NUM_PE, default `NUM_HASH_PE (power of two, >=2), meaning hash PE count; PE_LOG2=log2(NUM_PE).
REQ-003 The block SHALL have parameter AW, default `ADDR_WIDTH, meaning address width.
REQ-004 The block SHALL have parameter HW, default `HASH_BITS, meaning hash value width, with HW>PE_LOG2.
REQ-005 Port clk  in  1  clock; the block SHALL use reset rst_n, synchronous, active-low, and clock clk.
REQ-006 Port rst_n  in  1  synchronous active-low reset.
REQ-007 Ports input_valid in 1, input_ready out 1: window handshake.
REQ-008 Ports input_head_addr in AW (address of position 0), input_mask in ISSUE_W (position i present), input_hash_vec in ISSUE_W*HW, input_data in ISSUE_W*8, input_delim in 1.
REQ-009 Ports output_valid out 1, output_ready in 1: round handshake.
REQ-010 Ports output_mask out NUM_PE, output_addr_vec out NUM_PE*AW, output_hash_vec out NUM_PE*(HW-PE_LOG2), output_data out ISSUE_W*8, output_head_addr out AW, output_delim out 1, output_last out 1.

Function
REQ-011 A PE bank of position i SHALL be hash_i[PE_LOG2-1:0]; the bank-local hash SHALL be hash_i[HW-1:PE_LOG2].
REQ-012 On input handshake the block SHALL register head_addr, hash_vec, data, delim, and load pending bitmap := input_mask.
REQ-013 States SHALL be IDLE (no window held) and DISPATCH (window held); IDLE->DISPATCH on input handshake; DISPATCH->IDLE when the last round handshakes and no new window is accepted in that cycle.
REQ-014 In DISPATCH, output_valid SHALL be 1; each round, for every PE p, the lowest-index pending position with bank p SHALL be selected; output_mask[p]=1 if one exists.
REQ-015 For selected position i on PE p: output_addr_vec[p] = head_addr + i (modulo 2^AW); output_hash_vec[p] = bank-local hash of i; unselected lanes SHALL drive 0.
REQ-016 output_last SHALL be 1 when the current round clears all pending bits; output_delim SHALL equal registered delim AND output_last.
REQ-017 On round handshake, the selected bits SHALL clear from pending; while output_valid & ~output_ready, all outputs SHALL hold stable.
REQ-018 input_ready SHALL be ~busy | (output_valid & output_ready & output_last), giving zero-bubble back-to-back windows.
REQ-019 A window with input_mask==0 SHALL produce exactly one round with output_mask=0, output_last=1, output_delim=input_delim.
REQ-020 Rounds per window SHALL equal the max count of present positions sharing one bank (min 1).
REQ-021 First round of an accepted window SHALL be valid the cycle after acceptance; outputs SHALL depend only on registers (no input-to-output combinational path).
REQ-022 output_data and output_head_addr SHALL carry the window's registered values on every round.

Reset
REQ-023 While rst_n=0 at a clk edge: state:=IDLE, pending:=0, output_valid=0, input_ready=1 after release, all perf counters:=0.
REQ-024 Reset mid-window SHALL discard the held window with no further rounds emitted.
REQ-025 Output data fields SHALL read 0 after reset until the first window is accepted.

Configuration
REQ-026 With PRE_HASH_DISPATCH_PERF_EN defined, ports perf_window_cnt, perf_round_cnt, perf_conflict_cnt (each out 32) SHALL exist: windows accepted, rounds handshaken, rounds handshaken beyond the first of each window; all saturate at 2^32-1.
REQ-027 Without PRE_HASH_DISPATCH_PERF_EN, the perf ports and counters SHALL be absent; functional behaviour identical.

Verification (ISSUE_W=4, NUM_PE=4, AW=32, HW=12)
REQ-028 Conflict-free: head=100, mask=1111, banks 0,1,2,3, ready=1 -> one round, mask=1111, addrs 100..103, last=1.
REQ-029 Full conflict: banks all 2, mask=1111 -> four rounds, each mask=0100, addrs 100,101,102,103 in order; last only on fourth.
REQ-030 Backpressure: banks 0,0,1,1, ready low 3 cycles on round 1 -> round 1 held stable (mask=0011, addrs 100,102), then round 2 (addrs 101,103); input_ready=0 throughout stall.
REQ-031 Empty delim window: mask=0000, delim=1 -> single round, mask=0000, last=1, delim=1.
REQ-032 Back-to-back: two conflict-free windows (head 0, head 4) with input_valid held -> rounds on consecutive cycles, no bubble; delim asserted only on the window that carried it.
REQ-033 Reset during round 2 of a full-conflict window -> output_valid=0 next cycle; with PRE_HASH_DISPATCH_PERF_EN, counters read 0; next window dispatches normally.
